core_ctrl: RTL and testbench

- Multi-cycle sequencer for the RV32I core.
- Drives the instruction-fetch and data-memory handshakes, latches the instruction register, and decides when the PC and register file are written.
- Consumes the instruction decoder's control outputs and the ALU compare result.
- Sits between the memory interfaces and the decode/execute datapath; one instruction is in flight at a time.

---
 rtl/toothless_pkg.sv | 32 +++
 rtl/core_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_core_ctrl.sv | 294 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toothless_pkg.sv
// Shared types and constants for the toothless RV32I core.
package toothless_pkg;

    localparam int unsigned CTRL_TRANS_W = 2;
    localparam int unsigned PC_SEL_W     = 2;
    localparam int unsigned TRAP_CAUSE_W = 2;

    localparam logic [CTRL_TRANS_W-1:0] CTRL_TRANS_SEL_NONE   = 2'b00;
    localparam logic [CTRL_TRANS_W-1:0] CTRL_TRANS_SEL_JUMP   = 2'b01;
    localparam logic [CTRL_TRANS_W-1:0] CTRL_TRANS_SEL_BRANCH = 2'b10;

    localparam logic [PC_SEL_W-1:0] PC_SEL_PLUS4  = 2'b00;
    localparam logic [PC_SEL_W-1:0] PC_SEL_JUMP   = 2'b01;
    localparam logic [PC_SEL_W-1:0] PC_SEL_BRANCH = 2'b10;

    localparam logic [TRAP_CAUSE_W-1:0] TRAP_NONE    = 2'b00;
    localparam logic [TRAP_CAUSE_W-1:0] TRAP_ILLEGAL = 2'b01;
    localparam logic [TRAP_CAUSE_W-1:0] TRAP_BUSERR  = 2'b10;
    localparam logic [TRAP_CAUSE_W-1:0] TRAP_TIMEOUT = 2'b11;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        FETCH_REQ  = 3'd1,
        FETCH_WAIT = 3'd2,
        EXECUTE    = 3'd3,
        MEM_REQ    = 3'd4,
        MEM_WAIT   = 3'd5,
        WRITEBACK  = 3'd6,
        TRAP       = 3'd7
    } ctrl_state_e;

endpackage

// File: rtl/core_ctrl.sv
// Multi-cycle sequencer: fetch/data handshakes, IR load, PC/RF write strobes,
// retire counter and trap handling. One instruction in flight at a time.
module core_ctrl
    import toothless_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    fetch_enable_i,
    output logic                    instr_req_o,
    input  logic                    instr_gnt_i,
    input  logic                    instr_rvalid_i,
    output logic                    ir_we_o,
    input  logic                    instr_invalid_i,
    input  logic [CTRL_TRANS_W-1:0] ctrl_trans_instr_i,
    input  logic                    data_req_i,
    input  logic                    data_we_i,
    input  logic                    rd_used_i,
    input  logic                    branch_taken_i,
    output logic                    data_req_o,
    output logic                    data_we_o,
    input  logic                    data_gnt_i,
    input  logic                    data_rvalid_i,
    input  logic                    data_err_i,
    output logic                    rf_we_o,
    output logic                    rf_wsrc_lsu_o,
    output logic                    pc_we_o,
    output logic [PC_SEL_W-1:0]     pc_sel_o,
    output logic [CNT_WIDTH-1:0]    instr_cnt_o,
    output logic                    trap_o,
    output logic [TRAP_CAUSE_W-1:0] trap_cause_o
);

    localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYCLES - 1);

    ctrl_state_e             state_q, state_d;
    logic [TMO_W-1:0]        tmo_q, tmo_d;
    logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
    logic [TRAP_CAUSE_W-1:0] cause_q, cause_d;
    logic                    tmo_expired;
    logic                    in_wait_state;

    // State and counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tmo_q   <= '0;
            cnt_q   <= '0;
            cause_q <= TRAP_NONE;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
            cnt_q   <= cnt_d;
            cause_q <= cause_d;
        end
    end

    // Next-state; an exit condition always beats an expiring timeout
    always_comb begin
        state_d     = state_q;
        cause_d     = cause_q;
        tmo_expired = (tmo_q == TMO_LIMIT);
        unique case (state_q)
            IDLE: begin
                if (fetch_enable_i) state_d = FETCH_REQ;
            end
            FETCH_REQ: begin
                if (instr_gnt_i) begin
                    state_d = FETCH_WAIT;
                end else if (tmo_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            FETCH_WAIT: begin
                if (instr_rvalid_i) begin
                    state_d = EXECUTE;
                end else if (tmo_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            EXECUTE: begin
                if (instr_invalid_i) begin
                    state_d = TRAP;
                    cause_d = TRAP_ILLEGAL;
                end else if (data_req_i) begin
                    state_d = MEM_REQ;
                end else begin
                    state_d = WRITEBACK;
                end
            end
            MEM_REQ: begin
                if (data_gnt_i) begin
                    state_d = MEM_WAIT;
                end else if (tmo_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            MEM_WAIT: begin
                if (data_rvalid_i) begin
                    if (data_err_i) begin
                        state_d = TRAP;
                        cause_d = TRAP_BUSERR;
                    end else begin
                        state_d = WRITEBACK;
                    end
                end else if (tmo_expired) begin
                    state_d = TRAP;
                    cause_d = TRAP_TIMEOUT;
                end
            end
            WRITEBACK: begin
                state_d = fetch_enable_i ? FETCH_REQ : IDLE;
            end
            TRAP: begin
                state_d = TRAP;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Timeout counts only while dwelling in a handshake state; any transition clears it
    always_comb begin
        in_wait_state = (state_q == FETCH_REQ) || (state_q == FETCH_WAIT) ||
                        (state_q == MEM_REQ)   || (state_q == MEM_WAIT);
        tmo_d = '0;
        if (in_wait_state && (state_d == state_q)) begin
            tmo_d = tmo_q + TMO_W'(1);
        end
        cnt_d = cnt_q;
        if (state_q == WRITEBACK) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Output decode
    always_comb begin
        instr_req_o   = 1'b0;
        ir_we_o       = 1'b0;
        data_req_o    = 1'b0;
        data_we_o     = 1'b0;
        rf_we_o       = 1'b0;
        rf_wsrc_lsu_o = 1'b0;
        pc_we_o       = 1'b0;
        pc_sel_o      = PC_SEL_PLUS4;
        trap_o        = 1'b0;
        trap_cause_o  = cause_q;
        instr_cnt_o   = cnt_q;
        unique case (state_q)
            FETCH_REQ: begin
                instr_req_o = 1'b1;
            end
            FETCH_WAIT: begin
                ir_we_o = instr_rvalid_i;
            end
            MEM_REQ: begin
                data_req_o = 1'b1;
                data_we_o  = data_we_i;
            end
            WRITEBACK: begin
                pc_we_o       = 1'b1;
                rf_we_o       = rd_used_i;
                rf_wsrc_lsu_o = data_req_i & ~data_we_i;
                if (ctrl_trans_instr_i == CTRL_TRANS_SEL_JUMP) begin
                    pc_sel_o = PC_SEL_JUMP;
                end else if ((ctrl_trans_instr_i == CTRL_TRANS_SEL_BRANCH) && branch_taken_i) begin
                    pc_sel_o = PC_SEL_BRANCH;
                end
            end
            TRAP: begin
                trap_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_core_ctrl.sv
// Directed self-checking bench for core_ctrl (CNT_WIDTH=4 to exercise wrap).
module tb_core_ctrl;
    import toothless_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       fetch_enable_i;
    logic       instr_req_o;
    logic       instr_gnt_i;
    logic       instr_rvalid_i;
    logic       ir_we_o;
    logic       instr_invalid_i;
    logic [1:0] ctrl_trans_instr_i;
    logic       data_req_i;
    logic       data_we_i;
    logic       rd_used_i;
    logic       branch_taken_i;
    logic       data_req_o;
    logic       data_we_o;
    logic       data_gnt_i;
    logic       data_rvalid_i;
    logic       data_err_i;
    logic       rf_we_o;
    logic       rf_wsrc_lsu_o;
    logic       pc_we_o;
    logic [1:0] pc_sel_o;
    logic [3:0] instr_cnt_o;
    logic       trap_o;
    logic [1:0] trap_cause_o;

    int errors = 0;
    int checks = 0;
    int dual_req = 0;

    core_ctrl #(.CNT_WIDTH(4), .TIMEOUT_CYCLES(16)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .fetch_enable_i    (fetch_enable_i),
        .instr_req_o       (instr_req_o),
        .instr_gnt_i       (instr_gnt_i),
        .instr_rvalid_i    (instr_rvalid_i),
        .ir_we_o           (ir_we_o),
        .instr_invalid_i   (instr_invalid_i),
        .ctrl_trans_instr_i(ctrl_trans_instr_i),
        .data_req_i        (data_req_i),
        .data_we_i         (data_we_i),
        .rd_used_i         (rd_used_i),
        .branch_taken_i    (branch_taken_i),
        .data_req_o        (data_req_o),
        .data_we_o         (data_we_o),
        .data_gnt_i        (data_gnt_i),
        .data_rvalid_i     (data_rvalid_i),
        .data_err_i        (data_err_i),
        .rf_we_o           (rf_we_o),
        .rf_wsrc_lsu_o     (rf_wsrc_lsu_o),
        .pc_we_o           (pc_we_o),
        .pc_sel_o          (pc_sel_o),
        .instr_cnt_o       (instr_cnt_o),
        .trap_o            (trap_o),
        .trap_cause_o      (trap_cause_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rst_n && instr_req_o && data_req_o) dual_req++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    task automatic clear_inputs;
        instr_gnt_i        = 1'b0;
        instr_rvalid_i     = 1'b0;
        instr_invalid_i    = 1'b0;
        ctrl_trans_instr_i = CTRL_TRANS_SEL_NONE;
        data_req_i         = 1'b0;
        data_we_i          = 1'b0;
        rd_used_i          = 1'b0;
        branch_taken_i     = 1'b0;
        data_gnt_i         = 1'b0;
        data_rvalid_i      = 1'b0;
        data_err_i         = 1'b0;
    endtask

    // Leaves the core in FETCH_REQ, two time units after the edge
    task automatic do_reset;
        rst_n          = 1'b0;
        fetch_enable_i = 1'b0;
        clear_inputs();
        tick();
        tick();
        rst_n          = 1'b1;
        fetch_enable_i = 1'b1;
        tick();
    endtask

    // Runs one instruction from FETCH_REQ; fg = wait cycles before grant,
    // fr = FETCH_WAIT cycles up to and including rvalid (same for dg/dr on data side)
    task automatic run_instr(input string tag, input int fg, input int fr, input logic inv,
                             input logic [1:0] tr, input logic dreq, input logic dwe,
                             input logic rdu, input logic bt, input int dg, input int dr,
                             input logic derr, input logic fe_drop, input logic exp_rf,
                             input logic exp_lsu, input logic [1:0] exp_sel,
                             input logic [1:0] exp_cause, input int exp_cyc);
        int cyc;
        int bad;
        cyc = 0;
        bad = 0;
        instr_invalid_i    = inv;
        ctrl_trans_instr_i = tr;
        data_req_i         = dreq;
        data_we_i          = dwe;
        rd_used_i          = rdu;
        branch_taken_i     = bt;
        for (int i = 0; i <= fg; i++) begin
            instr_gnt_i = (i == fg);
            #1;
            if (!instr_req_o || data_req_o || ir_we_o || pc_we_o || rf_we_o) bad++;
            tick();
            cyc++;
        end
        instr_gnt_i = 1'b0;
        for (int i = 1; i <= fr; i++) begin
            instr_rvalid_i = (i == fr);
            #1;
            if ((ir_we_o !== (i == fr)) || instr_req_o || rf_we_o) bad++;
            tick();
            cyc++;
        end
        instr_rvalid_i = 1'b0;
        #1;
        if (pc_we_o || rf_we_o || instr_req_o || data_req_o || ir_we_o) bad++;
        tick();
        cyc++;
        if (dreq && !inv) begin
            for (int i = 0; i <= dg; i++) begin
                data_gnt_i = (i == dg);
                #1;
                if (!data_req_o || (data_we_o !== dwe) || instr_req_o || rf_we_o) bad++;
                tick();
                cyc++;
            end
            data_gnt_i = 1'b0;
            for (int i = 1; i <= dr; i++) begin
                data_rvalid_i = (i == dr);
                data_err_i    = (i == dr) && derr;
                if (fe_drop) fetch_enable_i = 1'b0;
                #1;
                if (data_req_o || instr_req_o || rf_we_o || pc_we_o) bad++;
                tick();
                cyc++;
            end
            data_rvalid_i = 1'b0;
            data_err_i    = 1'b0;
        end
        check({tag, "_phases"}, 32'(bad), 32'd0);
        if (exp_cause == TRAP_NONE) begin
            #1;
            check({tag, "_wb_pc_we"}, 32'(pc_we_o), 32'd1);
            check({tag, "_wb_rf_we"}, 32'(rf_we_o), 32'(exp_rf));
            check({tag, "_wb_lsu"}, 32'(rf_wsrc_lsu_o), 32'(exp_lsu));
            check({tag, "_wb_pc_sel"}, 32'(pc_sel_o), 32'(exp_sel));
            tick();
            cyc++;
        end
        check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
        check({tag, "_trap"}, 32'(trap_o), 32'(exp_cause != TRAP_NONE));
        check({tag, "_cause"}, 32'(trap_cause_o), 32'(exp_cause));
    endtask

    initial begin
        int n;
        int bad;
        clear_inputs();
        rst_n          = 1'b0;
        fetch_enable_i = 1'b0;
        tick();
        #1;
        check("rst_outputs", {26'd0, instr_req_o, data_req_o, ir_we_o, rf_we_o, pc_we_o, trap_o}, 32'd0);
        check("rst_cnt", 32'(instr_cnt_o), 32'd0);
        check("rst_cause", 32'(trap_cause_o), 32'd0);

        // Start, then asynchronous reset while requesting
        do_reset();
        #1;
        check("start_req", 32'(instr_req_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req", 32'(instr_req_o), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        #1;
        check("restart_req", 32'(instr_req_o), 32'd1);

        // Three ADDs back to back
        do_reset();
        for (int k = 0; k < 3; k++)
            run_instr("add", 0, 1, 0, CTRL_TRANS_SEL_NONE, 0, 0, 1, 0, 0, 0, 0, 0,
                      1, 0, PC_SEL_PLUS4, TRAP_NONE, 4);
        check("add_cnt", 32'(instr_cnt_o), 32'd3);

        // Load with waits, store, branches, jump
        run_instr("load", 0, 1, 0, CTRL_TRANS_SEL_NONE, 1, 0, 1, 0, 3, 2, 0, 0,
                  1, 1, PC_SEL_PLUS4, TRAP_NONE, 10);
        run_instr("store", 0, 1, 0, CTRL_TRANS_SEL_NONE, 1, 1, 0, 0, 0, 1, 0, 0,
                  0, 0, PC_SEL_PLUS4, TRAP_NONE, 6);
        run_instr("br_taken", 0, 1, 0, CTRL_TRANS_SEL_BRANCH, 0, 0, 0, 1, 0, 0, 0, 0,
                  0, 0, PC_SEL_BRANCH, TRAP_NONE, 4);
        run_instr("br_not", 0, 1, 0, CTRL_TRANS_SEL_BRANCH, 0, 0, 0, 0, 0, 0, 0, 0,
                  0, 0, PC_SEL_PLUS4, TRAP_NONE, 4);
        run_instr("jal", 0, 1, 0, CTRL_TRANS_SEL_JUMP, 0, 0, 1, 0, 0, 0, 0, 0,
                  1, 0, PC_SEL_JUMP, TRAP_NONE, 4);
        check("mix_cnt", 32'(instr_cnt_o), 32'd8);

        // Grant and rvalid exactly at the timeout limit still proceed
        run_instr("tmo_edge", 15, 16, 0, CTRL_TRANS_SEL_NONE, 0, 0, 1, 0, 0, 0, 0, 0,
                  1, 0, PC_SEL_PLUS4, TRAP_NONE, 34);

        // Fetch disabled during MEM_WAIT: load retires, core parks in IDLE
        run_instr("fe_drop", 0, 1, 0, CTRL_TRANS_SEL_NONE, 1, 0, 1, 0, 0, 2, 0, 1,
                  1, 1, PC_SEL_PLUS4, TRAP_NONE, 7);
        bad = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (instr_req_o || data_req_o || pc_we_o) bad++;
            tick();
        end
        check("fe_drop_idle", 32'(bad), 32'd0);
        check("fe_drop_cnt", 32'(instr_cnt_o), 32'd10);

        // Retire counter wraps modulo 16
        do_reset();
        for (int k = 0; k < 17; k++)
            run_instr("wrap", 0, 1, 0, CTRL_TRANS_SEL_NONE, 0, 0, 1, 0, 0, 0, 0, 0,
                      1, 0, PC_SEL_PLUS4, TRAP_NONE, 4);
        check("wrap_cnt", 32'(instr_cnt_o), 32'd1);

        // Illegal instruction trap after one retired ADD
        do_reset();
        run_instr("pre_ill", 0, 1, 0, CTRL_TRANS_SEL_NONE, 0, 0, 1, 0, 0, 0, 0, 0,
                  1, 0, PC_SEL_PLUS4, TRAP_NONE, 4);
        run_instr("illegal", 0, 1, 1, CTRL_TRANS_SEL_NONE, 0, 0, 1, 0, 0, 0, 0, 0,
                  0, 0, PC_SEL_PLUS4, TRAP_ILLEGAL, 3);
        instr_gnt_i    = 1'b1;
        instr_rvalid_i = 1'b1;
        bad = 0;
        for (int k = 0; k < 20; k++) begin
            #1;
            if (instr_req_o || data_req_o || pc_we_o || rf_we_o || ir_we_o || !trap_o) bad++;
            tick();
        end
        clear_inputs();
        check("ill_quiet", 32'(bad), 32'd0);
        check("ill_cnt", 32'(instr_cnt_o), 32'd1);
        check("ill_cause_held", 32'(trap_cause_o), 32'(TRAP_ILLEGAL));

        // Data bus error
        do_reset();
        run_instr("buserr", 0, 1, 0, CTRL_TRANS_SEL_NONE, 1, 0, 1, 0, 0, 1, 1, 0,
                  0, 0, PC_SEL_PLUS4, TRAP_BUSERR, 5);
        check("buserr_cnt", 32'(instr_cnt_o), 32'd0);

        // Fetch grant never arrives
        do_reset();
        n = 0;
        for (int k = 0; k < 40; k++) begin
            #1;
            if (!instr_req_o) break;
            n++;
            tick();
        end
        check("tmo_req_cycles", 32'(n), 32'd16);
        check("tmo_trap", 32'(trap_o), 32'd1);
        check("tmo_cause", 32'(trap_cause_o), 32'(TRAP_TIMEOUT));

        check("no_dual_req", 32'(dual_req), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
